// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants: ALU op codes, branch funct3 codes, forward selects.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;
    localparam logic [3:0] ALU_AUIPC  = 4'd11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; reserved op codes produce zero.
module alu
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $signed(a) >>> shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_PASS_B: result = b;
            ALU_AUIPC:  result = a + b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = rv_pkg::XLEN,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [3:0]      alu_op_i,
    input  logic            alu_src_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            reg_write_i,
    input  logic            mem_to_reg_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic [1:0]      forwardA_i,
    input  logic [1:0]      forwardB_i,
    input  logic            forwardC_i,
    input  logic [XLEN-1:0] ex_mem_result_i,
    input  logic [XLEN-1:0] mem_wb_data_i,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_target_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [RA_W-1:0] rd_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            reg_write_o,
    output logic            mem_to_reg_o,
    output logic            forwardC_o,
    output logic            valid_o
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] result_sel;
    logic            cond;

    // EX/MEM hit (bit1) beats MEM/WB hit: it is the younger producer.
    always_comb begin
        fwd_a = rs1_data_i;
        if (forwardA_i[1])
            fwd_a = ex_mem_result_i;
        else if (forwardA_i == FWD_WB)
            fwd_a = mem_wb_data_i;
    end

    always_comb begin
        fwd_b = rs2_data_i;
        if (forwardB_i[1])
            fwd_b = ex_mem_result_i;
        else if (forwardB_i == FWD_WB)
            fwd_b = mem_wb_data_i;
    end

    assign alu_a = (alu_op_i == ALU_AUIPC) ? pc_i : fwd_a;
    assign alu_b = alu_src_i ? imm_i : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op_i),
        .result (alu_out)
    );

    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond = (fwd_a == fwd_b);
            F3_BNE:  cond = (fwd_a != fwd_b);
            F3_BLT:  cond = ($signed(fwd_a) <  $signed(fwd_b));
            F3_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            F3_BLTU: cond = (fwd_a <  fwd_b);
            F3_BGEU: cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken_o  = (branch_i & cond) | jal_i | jalr_i;
    assign branch_target_o = jalr_i ? ((fwd_a + imm_i) & ~XLEN'(1)) : (pc_i + imm_i);

    assign pc_plus4   = pc_i + XLEN'(4);
    assign result_sel = (jal_i | jalr_i) ? pc_plus4 : alu_out;

    // EX/MEM register; reset and flush both leave a zeroed bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            alu_result_o <= '0;
            store_data_o <= '0;
            pc_plus4_o   <= '0;
            rd_o         <= '0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            forwardC_o   <= 1'b0;
            valid_o      <= 1'b0;
        end else if (!stall_i) begin
            alu_result_o <= result_sel;
            store_data_o <= fwd_b;
            pc_plus4_o   <= pc_plus4;
            rd_o         <= rd_i;
            mem_read_o   <= mem_read_i;
            mem_write_o  <= mem_write_i;
            reg_write_o  <= reg_write_i;
            mem_to_reg_o <= mem_to_reg_i;
            forwardC_o   <= forwardC_i & mem_write_i;
            valid_o      <= 1'b1;
        end
    end

endmodule
